// File: rtl/bin_to_bcd_encoder.sv
// Sequential binary-to-BCD encoder (double dabble), one input bit per clock.
// Results that do not fit in DIGITS decimal digits are shown as all-dash codes (4'ha).
module bin_to_bcd_encoder #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int INT_DIGITS = (BIN_WIDTH + 2) / 3;
  localparam int ACC_W      = 4 * INT_DIGITS;
  localparam int MAX_DIGITS = (DIGITS > INT_DIGITS) ? DIGITS : INT_DIGITS;
  localparam int CNT_W      = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t               state, state_next;
  logic [ACC_W-1:0]     acc;
  logic [BIN_WIDTH-1:0] sh;
  logic [CNT_W-1:0]     cnt;

  // Add 3 to every accumulator digit >= 5 so the following shift carries correctly.
  function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int i = 0; i < INT_DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Returns {ovf, digits}: dashes when any digit above the displayed range is non-zero.
  function automatic logic [4*DIGITS:0] saturate(input logic [ACC_W-1:0] a);
    logic [4*MAX_DIGITS-1:0] ext;
    ext = '0;
    ext[ACC_W-1:0] = a;
    if ((ext >> (4*DIGITS)) != '0) return {1'b1, {DIGITS{4'ha}}};
    else                          return {1'b0, ext[4*DIGITS-1:0]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_W'(BIN_WIDTH - 1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      bcd_out <= '0;
    end else begin
      done <= 1'b0;
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            sh  <= bin_in;
            acc <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          {acc, sh} <= {add3(acc), sh} << 1;
          cnt       <= cnt + 1'b1;
        end
        FINISH: begin
          {ovf, bcd_out} <= saturate(acc);
          done           <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_encoder.sv
// Directed bench for bin_to_bcd_encoder: default 16-bit/4-digit instance plus an 8-bit/2-digit instance.
module tb_bin_to_bcd_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bin_in;
  logic        busy, done, ovf;
  logic [15:0] bcd_out;

  logic        start8;
  logic [7:0]  bin8;
  logic        busy8, done8, ovf8;
  logic [7:0]  bcd8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_encoder #(.BIN_WIDTH(16), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .ovf(ovf), .bcd_out(bcd_out)
  );

  bin_to_bcd_encoder #(.BIN_WIDTH(8), .DIGITS(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin_in(bin8),
    .busy(busy8), .done(done8), .ovf(ovf8), .bcd_out(bcd8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference: decimal digits by division, dashes above 9999.
  function automatic logic [16:0] ref16(input int v);
    logic [15:0] r;
    int x;
    if (v > 9999) return {1'b1, 16'haaaa};
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {1'b0, r};
  endfunction

  // Called at a sample point (#1 after an edge). inject_at > 0 pulses start with 777 mid-conversion.
  task automatic convert(input logic [15:0] v, input logic [15:0] exp_bcd, input logic exp_ovf,
                         input int inject_at, input string tag);
    int n, busy_cnt;
    logic held;
    logic [15:0] prev;
    prev = bcd_out;
    held = 1'b1;
    start = 1'b1;
    bin_in = v;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (n < 40 && !done) begin
      if (busy) busy_cnt++;
      if (bcd_out !== prev) held = 1'b0;
      @(posedge clk); #1;
      n++;
      start = (n == inject_at);
      if (n == inject_at) bin_in = 16'd777;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, 17);
    check({tag, "_busy_cycles"}, busy_cnt, 17);
    check({tag, "_bcd"}, bcd_out, exp_bcd);
    check({tag, "_ovf"}, ovf, exp_ovf);
    check({tag, "_held"}, held, 1'b1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic convert8(input logic [7:0] v, input logic [7:0] exp_bcd, input logic exp_ovf,
                          input string tag);
    int n;
    start8 = 1'b1;
    bin8 = v;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (n < 30 && !done8) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, 9);
    check({tag, "_bcd"}, bcd8, exp_bcd);
    check({tag, "_ovf"}, ovf8, exp_ovf);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic seen_done;
    logic [16:0] r;
    int v;

    rst = 1'b1; start = 1'b0; bin_in = '0; start8 = 1'b0; bin8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_bcd", bcd_out, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;

    convert(16'd1234, 16'h1234, 1'b0, 0, "c1234");
    convert(16'd9999, 16'h9999, 1'b0, 0, "c9999");

    // Asynchronous reset in the middle of an idle cycle clears outputs before any edge.
    #2 rst = 1'b1;
    #1;
    check("async_bcd", bcd_out, 16'h0000);
    check("async_ovf", ovf, 1'b0);
    check("async_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    convert(16'd10000, 16'haaaa, 1'b1, 0, "c10000");
    convert(16'd65535, 16'haaaa, 1'b1, 0, "c65535");
    convert(16'd0,     16'h0000, 1'b0, 0, "c0");
    convert(16'd42,    16'h0042, 1'b0, 5, "c42_ignore");

    // Start held high: second request accepted in the done cycle.
    start = 1'b1;
    bin_in = 16'd305;
    @(posedge clk); #1;
    bin_in = 16'd8000;
    n = 0;
    while (n < 40 && !done) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_first_bcd", bcd_out, 16'h0305);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 2) start = 1'b0;
    end while (n < 40 && !done);
    start = 1'b0;
    check("b2b_spacing", n, 18);
    check("b2b_second_bcd", bcd_out, 16'h8000);
    @(posedge clk); #1;

    // Reset during conversion discards it.
    start = 1'b1;
    bin_in = 16'd5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_bcd", bcd_out, 16'h0000);
    check("midrst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("midrst_no_done", seen_done, 1'b0);
    convert(16'd5678, 16'h5678, 1'b0, 0, "c5678");

    // Boundary and pseudo-random values against the division reference.
    for (int i = 0; i < 12; i++) begin
      case (i)
        0: v = 1;      1: v = 9;     2: v = 10;    3: v = 99;
        4: v = 100;    5: v = 1000;  6: v = 10001; 7: v = 32768;
        default: v = int'($urandom_range(0, 65535));
      endcase
      r = ref16(v);
      convert(16'(v), r[15:0], r[16], 0, "sweep");
    end

    convert8(8'd255, 8'haa, 1'b1, "w8_255");
    convert8(8'd99,  8'h99, 1'b0, "w8_99");
    convert8(8'd100, 8'haa, 1'b1, "w8_100");
    convert8(8'd57,  8'h57, 1'b0, "w8_57");
    convert8(8'd0,   8'h00, 1'b0, "w8_0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
